pulse_train_ctrl: RTL
=====================

# pulse_train_ctrl

Programmable pulse-train controller that sequences a single pulse output through a fixed number of high/low periods derived from the system clock. It generalises the fixed divide-by-3 toggling pulse into a start/stop-controlled generator with programmable high length, low length and pulse count. It sits between a control source (testbench or higher-level FSM) and any logic consuming a timed pulse, and reports busy/done status.

## Interface
- CNT_W, 8, width of high/low phase length fields (cycles)
- NUM_W, 8, width of pulse-count field
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a pulse train; sampled only in IDLE
- abort  in  1  stop current train immediately
- high_len  in  CNT_W  cycles signal stays high per pulse
- low_len  in  CNT_W  cycles signal stays low per pulse
- num_pulses  in  NUM_W  pulses per train
- signal  out  1  registered pulse output
- busy  out  1  high while a train is running
- done  out  1  one-cycle strobe at normal train completion
- pulse_idx  out  NUM_W  index of current pulse, 0-based

## Operation
- States: IDLE, HIGH, LOW, DONE.
- Reset (any state, mid-train included): state=IDLE, signal=0, busy=0, done=0, pulse_idx=0, counters=0.
- IDLE: start=1 latches high_len, low_len, num_pulses into shadow registers; inputs ignored thereafter until IDLE returns.
- IDLE + start with num_pulses=0: go to DONE, no pulse emitted (see Configuration).
- IDLE + start otherwise: go to HIGH, phase counter loaded with high_len.
- HIGH: signal=1; counter decrements each cycle; at final cycle go LOW, load low_len.
- LOW: signal=0; at final cycle, if pulse_idx = latched count-1 go DONE, else pulse_idx+1 and go HIGH.
- DONE: done=1 for exactly one cycle, signal=0, then IDLE; pulse_idx reset to 0.
- high_len=0 or low_len=0 treated as 1 (phase never skipped).
- abort (HIGH/LOW): next state IDLE, signal=0, busy=0, no done strobe; abort has priority over phase transitions. abort in IDLE/DONE ignored.
- start while busy ignored; start and abort together in IDLE: start wins (abort ignored in IDLE).
- busy=1 in HIGH and LOW only.

## Timing
- All outputs registered; start sampled at edge k -> signal=1, busy=1 from edge k+1.
- Each pulse period = high_len + low_len cycles exactly; no idle cycles between pulses.
- Train of N pulses: done asserted at cycle k+1+N*(high_len+low_len), busy low in same cycle.
- Earliest restart: start sampled in the cycle after done (first IDLE cycle).
- abort sampled at edge m -> signal=0, busy=0 from edge m+1.
- Counter arithmetic unsigned, width CNT_W; no wrap since loaded length ≤ 2^CNT_W-1. pulse_idx never exceeds count-1.

## Configuration
- Macro PULSE_TRAIN_CONTINUOUS_EN.
- Defined: num_pulses=0 means continuous train; runs HIGH/LOW indefinitely until abort or reset, done never strobes, pulse_idx wraps modulo 2^NUM_W.
- Not defined: num_pulses=0 goes straight to DONE (one-cycle done, no pulse, busy stays 0).

## Structure
- Shared package pulse_pkg: state enum (IDLE, HIGH, LOW, DONE), default widths CNT_W/NUM_W.
- One sub-module: phase_counter (loadable down counter, CNT_W wide, zero-length clamp to 1, last-cycle flag output). Controller FSM in pulse_train_ctrl instantiates it once.

## Test plan
- high_len=3, low_len=3, num_pulses=4, start 1 cycle -> 4 periods of 6 cycles, signal high 3/low 3, done strobe at cycle 25 after start, pulse_idx 0..3.
- high_len=0, low_len=0, num_pulses=2 -> lengths clamped: pattern 1,0,1,0, done at cycle 5.
- Abort during 2nd HIGH of high_len=5, low_len=5, num_pulses=3 -> signal 0 and busy 0 next cycle, no done; new start then runs full train.
- start pulsed while busy with different lengths -> ignored, original train unchanged; reset mid-LOW -> all outputs 0 next cycle.
- num_pulses=0 without macro -> done at start+1, signal stays 0; with PULSE_TRAIN_CONTINUOUS_EN -> continuous 6-cycle period with lengths 3/3 for 300 cycles, no done, stops on abort.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and default widths for the pulse-train controller.
package pulse_pkg;

    localparam int CNT_W = 8;
    localparam int NUM_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_train_ctrl_if.sv
// Control/status bundle between a pulse-train requester (master) and the controller (slave).
interface pulse_train_ctrl_if #(
    parameter int CNT_W = pulse_pkg::CNT_W,
    parameter int NUM_W = pulse_pkg::NUM_W
);
    import pulse_pkg::*;

    logic             start;
    logic             abort;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [NUM_W-1:0] num_pulses;
    logic             signal;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulse_idx;
    state_t           state;

    // start is a request that is accepted only on a clock edge where state is IDLE
    // (the controller's implicit ready); it is otherwise dropped, not held pending.
    // abort is honoured only while busy; done is a one-cycle completion strobe.
    modport master (
        output start, abort, high_len, low_len, num_pulses,
        input  signal, busy, done, pulse_idx, state
    );

    modport slave (
        input  start, abort, high_len, low_len, num_pulses,
        output signal, busy, done, pulse_idx, state
    );

endinterface

// File: rtl/phase_counter.sv
// Loadable down counter timing one HIGH or LOW phase; a zero length is run as one cycle.
module phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= (len == '0) ? CNT_W'(1) : len;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // The loaded value counts the cycles remaining in the phase, this one included.
    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/pulse_train_ctrl.sv
// Start/abort controlled generator of N high/low pulses with programmable phase lengths.
// Define PULSE_TRAIN_CONTINUOUS_EN to make num_pulses=0 run an endless train.
module pulse_train_ctrl #(
    parameter int CNT_W = pulse_pkg::CNT_W,
    parameter int NUM_W = pulse_pkg::NUM_W
) (
    input  logic              clock,
    input  logic              reset,
    pulse_train_ctrl_if.slave bus
);
    import pulse_pkg::*;

    state_t           state;
    logic             signal_q;
    logic             busy_q;
    logic             done_q;
    logic [NUM_W-1:0] pulse_idx_q;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] low_q;
    logic [NUM_W-1:0] num_q;

    logic             load;
    logic [CNT_W-1:0] load_len;
    logic             last;
    logic             zero_to_done;
    logic             last_pulse;

`ifdef PULSE_TRAIN_CONTINUOUS_EN
    assign zero_to_done = 1'b0;
    assign last_pulse   = (num_q != '0) && (pulse_idx_q == num_q - 1'b1);
`else
    assign zero_to_done = (bus.num_pulses == '0);
    assign last_pulse   = (pulse_idx_q == num_q - 1'b1);
`endif

    // The phase counter is reloaded on the same edge the FSM enters HIGH or LOW.
    always_comb begin
        load     = 1'b0;
        load_len = bus.high_len;
        case (state)
            IDLE: begin
                if (bus.start && !zero_to_done) begin
                    load     = 1'b1;
                    load_len = bus.high_len;
                end
            end
            HIGH: begin
                if (!bus.abort && last) begin
                    load     = 1'b1;
                    load_len = low_q;
                end
            end
            LOW: begin
                if (!bus.abort && last && !last_pulse) begin
                    load     = 1'b1;
                    load_len = high_q;
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .len   (load_len),
        .last  (last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            signal_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pulse_idx_q <= '0;
            high_q      <= '0;
            low_q       <= '0;
            num_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        high_q <= bus.high_len;
                        low_q  <= bus.low_len;
                        num_q  <= bus.num_pulses;
                        if (zero_to_done) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state    <= HIGH;
                            signal_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (bus.abort) begin
                        state       <= IDLE;
                        signal_q    <= 1'b0;
                        busy_q      <= 1'b0;
                        pulse_idx_q <= '0;
                    end else if (last) begin
                        state    <= LOW;
                        signal_q <= 1'b0;
                    end
                end
                LOW: begin
                    if (bus.abort) begin
                        state       <= IDLE;
                        signal_q    <= 1'b0;
                        busy_q      <= 1'b0;
                        pulse_idx_q <= '0;
                    end else if (last) begin
                        if (last_pulse) begin
                            state       <= DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            pulse_idx_q <= '0;
                        end else begin
                            state       <= HIGH;
                            signal_q    <= 1'b1;
                            pulse_idx_q <= pulse_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    pulse_idx_q <= '0;
                end
            endcase
        end
    end

    assign bus.signal    = signal_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_idx = pulse_idx_q;
    assign bus.state     = state;

endmodule
